// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared constants and types for the SPI register bank
package spi_regbank_pkg;

    localparam int INSTR_SIZE = 16;
    localparam int RW_BIT     = 15;
    localparam int W_MSB      = 14;
    localparam int W_LSB      = 13;
    localparam int ADDR_FIELD = 13;

    localparam logic [1:0] W_1      = 2'b00;
    localparam logic [1:0] W_2      = 2'b01;
    localparam logic [1:0] W_3      = 2'b10;
    localparam logic [1:0] W_STREAM = 2'b11;

    typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser with rise/fall event detection
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_regbank_sync.sv
// rtl/spi_regbank_sync.sv - oversampled SPI slave with ADI-style instructions and a register bank
module spi_regbank_sync
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int NUM_REGS  = 16,
    parameter logic [NUM_REGS*DATA_SIZE-1:0] RESET_VAL = '0,
    parameter logic [NUM_REGS-1:0]           RO_MASK   = '0
) (
    input  logic                          I_clk,
    input  logic                          _I_rstb,
    input  logic                          I_sclk,
    input  logic                          _I_csb,
    input  logic                          I_sdi,
    output logic                          O_sdo,
    output logic                          O_sdo_oe,
    input  logic [NUM_REGS*DATA_SIZE-1:0] I_ro_data,
    output logic [NUM_REGS*DATA_SIZE-1:0] O_regs,
    output logic                          O_wr_stb,
    output logic [ADDR_SIZE-1:0]          O_wr_addr,
    output logic                          O_busy
);

    localparam int SR_W  = (DATA_SIZE > INSTR_SIZE) ? DATA_SIZE : INSTR_SIZE;
    localparam int CNT_W = $clog2(SR_W) + 1;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic csb_lvl, csb_rise, csb_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(I_clk), .rst_n(_I_rstb), .din(I_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_csb (.clk(I_clk), .rst_n(_I_rstb), .din(_I_csb),
        .level(csb_lvl), .rise(csb_rise), .fall(csb_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sdi (.clk(I_clk), .rst_n(_I_rstb), .din(I_sdi),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SR_W-1:0]        sr_in;
    logic [DATA_SIZE-1:0]   sr_out;
    logic                   rw;
    logic [1:0]             w;
    logic [1:0]             word_cnt;
    logic [ADDR_SIZE-1:0]   addr;
    logic                   wr_pend;
    logic [ADDR_SIZE-1:0]   pend_addr;
    logic [DATA_SIZE-1:0]   pend_data;
    logic [DATA_SIZE-1:0]   regs [NUM_REGS];

    logic [SR_W-1:0]      sr_next;
    logic [ADDR_SIZE-1:0] instr_addr;
    logic [ADDR_SIZE-1:0] addr_dec;

    assign sr_next    = {sr_in[SR_W-2:0], sdi_lvl};
    assign instr_addr = sr_next[ADDR_SIZE-1:0];
    assign addr_dec   = addr - 1'b1;

    // Out-of-range addresses read as zero; read-only slots come from the live inputs.
    function automatic logic [DATA_SIZE-1:0] read_val(input logic [ADDR_SIZE-1:0] a);
        read_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (a == ADDR_SIZE'(i))
                read_val = RO_MASK[i] ? I_ro_data[i*DATA_SIZE +: DATA_SIZE] : regs[i];
    endfunction

    function automatic logic writable(input logic [ADDR_SIZE-1:0] a);
        writable = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (a == ADDR_SIZE'(i))
                writable = !RO_MASK[i];
    endfunction

    always_ff @(posedge I_clk or negedge _I_rstb) begin
        if (!_I_rstb) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr_in     <= '0;
            sr_out    <= '0;
            rw        <= 1'b0;
            w         <= W_1;
            word_cnt  <= '0;
            addr      <= '0;
            wr_pend   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            O_sdo     <= 1'b0;
            O_sdo_oe  <= 1'b0;
            O_wr_stb  <= 1'b0;
            O_wr_addr <= '0;
            O_busy    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VAL[i*DATA_SIZE +: DATA_SIZE];
        end else begin
            O_wr_stb <= 1'b0;
            O_busy   <= ~csb_lvl;

            // The word was fully received last cycle, so a pending write survives CSB rising now.
            if (wr_pend) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (pend_addr == ADDR_SIZE'(i))
                        regs[i] <= pend_data;
                O_wr_stb  <= 1'b1;
                O_wr_addr <= pend_addr;
                wr_pend   <= 1'b0;
            end

            if (csb_lvl) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                O_sdo    <= 1'b0;
                O_sdo_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csb_fall) begin
                            state    <= INSTR;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    INSTR: begin
                        if (sclk_rise) begin
                            sr_in <= sr_next;
                            if (bit_cnt == CNT_W'(INSTR_SIZE - 1)) begin
                                bit_cnt <= '0;
                                rw      <= sr_next[RW_BIT];
                                w       <= sr_next[W_MSB:W_LSB];
                                addr    <= instr_addr;
                                sr_out  <= read_val(instr_addr);
                                state   <= DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            sr_in <= sr_next;
                            if (bit_cnt == CNT_W'(DATA_SIZE - 1)) begin
                                bit_cnt  <= '0;
                                word_cnt <= word_cnt + 2'd1;
                                addr     <= addr_dec;
                                sr_out   <= read_val(addr_dec);
                                if (!rw && writable(addr)) begin
                                    wr_pend   <= 1'b1;
                                    pend_addr <= addr;
                                    pend_data <= sr_next[DATA_SIZE-1:0];
                                end
                                if (w != W_STREAM && word_cnt == w)
                                    state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            O_sdo  <= sr_out[DATA_SIZE-1];
                            sr_out <= sr_out << 1;
                            if (rw)
                                O_sdo_oe <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign O_regs[g*DATA_SIZE +: DATA_SIZE] = regs[g];
    end

endmodule

// File: tb/tb_spi_regbank_sync.sv
// tb/tb_spi_regbank_sync.sv - directed scoreboard bench for spi_regbank_sync
module tb_spi_regbank_sync;

    function automatic logic [127:0] mk_rv();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'h80 + 8'(i);
        return v;
    endfunction

    localparam logic [127:0] RV = mk_rv();

    logic         clk = 1'b0, rstb = 1'b0, sclk = 1'b0, csb = 1'b1, sdi = 1'b0;
    logic         sdo, sdo_oe, wr_stb, busy;
    logic [7:0]   wr_addr;
    logic [127:0] regs_o, ro_data;

    int total = 0, bad = 0, stb_cnt = 0, s0 = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  tx[$];
    logic [7:0]  mdl[16];
    logic [15:0] e_wr;

    spi_regbank_sync #(
        .ADDR_SIZE(8), .DATA_SIZE(8), .NUM_REGS(16),
        .RESET_VAL(RV), .RO_MASK(16'h0200)
    ) dut (
        .I_clk(clk), ._I_rstb(rstb), .I_sclk(sclk), ._I_csb(csb), .I_sdi(sdi),
        .O_sdo(sdo), .O_sdo_oe(sdo_oe), .I_ro_data(ro_data), .O_regs(regs_o),
        .O_wr_stb(wr_stb), .O_wr_addr(wr_addr), .O_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic fail(input string tag, input logic [127:0] o, input logic [127:0] e);
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    function automatic logic [127:0] pack_mdl();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (rstb && wr_stb) begin
            stb_cnt++;
            total++;
            if ((exp_wr.size() > 0) !== 1'b1) fail("strobe_expected", exp_wr.size(), 1);
            if (exp_wr.size() > 0) begin
                e_wr = exp_wr.pop_front();
                total++;
                if (wr_addr !== e_wr[15:8]) fail("strobe_addr", wr_addr, e_wr[15:8]);
                total++;
                if (regs_o[int'(e_wr[11:8])*8 +: 8] !== e_wr[7:0])
                    fail("strobe_data", regs_o[int'(e_wr[11:8])*8 +: 8], e_wr[7:0]);
            end
        end
    end

    task automatic send_bit(input logic b, output logic s, output logic oe);
        sdi = b;
        #40;
        s  = sdo;
        oe = sdo_oe;
        sclk = 1'b1;
        #50;
        sclk = 1'b0;
        #10;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        tx.push_back(d);
        exp_wr.push_back({a, d});
        mdl[a[3:0]] = d;
    endtask

    task automatic spi_txn(input logic [15:0] instr, input int nbits);
        logic s, oe, oe_instr, oe_all, oe_any;
        logic [7:0] txb, rxb, erd;
        oe_instr = 1'b0; oe_all = 1'b1; oe_any = 1'b0; txb = '0; rxb = '0;
        csb = 1'b0;
        #100;
        total++;
        if (busy !== 1'b1) fail("busy_active", busy, 1);
        for (int i = 15; i >= 0; i--) begin
            send_bit(instr[i], s, oe);
            oe_instr |= oe;
        end
        for (int n = 0; n < nbits; n++) begin
            if (n % 8 == 0) txb = (tx.size() > 0) ? tx.pop_front() : 8'h00;
            send_bit(txb[7 - n % 8], s, oe);
            rxb = {rxb[6:0], s};
            oe_all &= oe;
            oe_any |= oe;
            if (instr[15] && n % 8 == 7) begin
                total++;
                if ((exp_rd.size() > 0) !== 1'b1) fail("rd_expected", exp_rd.size(), 1);
                if (exp_rd.size() > 0) begin
                    erd = exp_rd.pop_front();
                    total++;
                    if (rxb !== erd) fail("rd_data", rxb, erd);
                end
            end
        end
        #100;
        csb = 1'b1;
        #200;
        total++;
        if (oe_instr !== 1'b0) fail("oe_instr_phase", oe_instr, 0);
        if (instr[15]) begin
            total++;
            if (oe_all !== 1'b1) fail("oe_read_data", oe_all, 1);
        end
        if (!instr[15]) begin
            total++;
            if (oe_any !== 1'b0) fail("oe_write_data", oe_any, 0);
        end
        total++;
        if (sdo_oe !== 1'b0) fail("oe_after_csb", sdo_oe, 0);
        total++;
        if (busy !== 1'b0) fail("busy_idle", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic s, oe;
        ro_data = '0;
        ro_data[9*8 +: 8] = 8'h3C;
        for (int i = 0; i < 16; i++) mdl[i] = RV[i*8 +: 8];
        #50 rstb = 1'b1;
        #50;
        total++;
        if (sdo !== 1'b0) fail("rst_sdo", sdo, 0);
        total++;
        if (sdo_oe !== 1'b0) fail("rst_oe", sdo_oe, 0);
        total++;
        if (wr_stb !== 1'b0) fail("rst_stb", wr_stb, 0);
        total++;
        if (wr_addr !== 8'h00) fail("rst_wr_addr", wr_addr, 0);
        total++;
        if (busy !== 1'b0) fail("rst_busy", busy, 0);
        total++;
        if (regs_o !== RV) fail("rst_regs", regs_o, RV);

        s0 = stb_cnt;
        push_wr(8'h06, 8'hA5);
        spi_txn(16'h0006, 8);
        total++;
        if (regs_o !== pack_mdl()) fail("single_write_regs", regs_o, pack_mdl());
        total++;
        if (wr_addr !== 8'h06) fail("single_write_addr", wr_addr, 8'h06);
        total++;
        if (stb_cnt - s0 !== 1) fail("single_write_strobes", stb_cnt - s0, 1);

        exp_rd.push_back(8'hA5);
        spi_txn(16'h8006, 8);

        s0 = stb_cnt;
        push_wr(8'h03, 8'h11);
        push_wr(8'h02, 8'h22);
        push_wr(8'h01, 8'h33);
        push_wr(8'h00, 8'h44);
        tx.push_back(8'h55);
        spi_txn(16'h6003, 40);
        total++;
        if (regs_o !== pack_mdl()) fail("stream_regs", regs_o, pack_mdl());
        total++;
        if (stb_cnt - s0 !== 4) fail("stream_strobes", stb_cnt - s0, 4);

        s0 = stb_cnt;
        push_wr(8'h05, 8'h01);
        push_wr(8'h04, 8'h02);
        tx.push_back(8'h03);
        spi_txn(16'h2005, 24);
        total++;
        if (regs_o !== pack_mdl()) fail("w2_regs", regs_o, pack_mdl());
        total++;
        if (stb_cnt - s0 !== 2) fail("w2_strobes", stb_cnt - s0, 2);

        s0 = stb_cnt;
        tx.push_back(8'hF0);
        spi_txn(16'h0002, 4);
        total++;
        if (regs_o !== pack_mdl()) fail("abort_regs", regs_o, pack_mdl());
        total++;
        if (stb_cnt - s0 !== 0) fail("abort_strobes", stb_cnt - s0, 0);
        push_wr(8'h02, 8'h77);
        spi_txn(16'h0002, 8);
        total++;
        if (regs_o !== pack_mdl()) fail("after_abort_regs", regs_o, pack_mdl());
        total++;
        if (stb_cnt - s0 !== 1) fail("after_abort_strobes", stb_cnt - s0, 1);

        s0 = stb_cnt;
        tx.push_back(8'hFF);
        spi_txn(16'h0009, 8);
        total++;
        if (stb_cnt - s0 !== 0) fail("ro_write_strobes", stb_cnt - s0, 0);
        total++;
        if (regs_o !== pack_mdl()) fail("ro_write_regs", regs_o, pack_mdl());
        exp_rd.push_back(8'h3C);
        spi_txn(16'h8009, 8);
        exp_rd.push_back(8'h00);
        spi_txn(16'h8014, 8);

        csb = 1'b0;
        #100;
        for (int i = 15; i >= 8; i--) send_bit(1'b0, s, oe);
        rstb = 1'b0;
        #30;
        total++;
        if (regs_o !== RV) fail("midreset_regs", regs_o, RV);
        rstb = 1'b1;
        #50;
        csb = 1'b1;
        #200;
        for (int i = 0; i < 16; i++) mdl[i] = RV[i*8 +: 8];
        total++;
        if (regs_o !== pack_mdl()) fail("post_reset_regs", regs_o, pack_mdl());
        exp_rd.push_back(8'h86);
        spi_txn(16'h8006, 8);

        total++;
        if (exp_wr.size() !== 0) fail("wr_queue_empty", exp_wr.size(), 0);
        total++;
        if (exp_rd.size() !== 0) fail("rd_queue_empty", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_regbank_sync.md
Name: spi_regbank_sync

Overview:
- Parametrised successor of the SPI-clocked register front end.
- The SPI slave runs entirely in the system clock domain: SCLK, CSB and SDI are oversampled.
- Supports ADI-style 16-bit instruction words with 1/2/3-word or streaming transfers and address auto-decrement.
- Provides a configurable bank of read/write and read-only registers, with a write strobe for downstream logic.
- Sits between the top-level SPI pins (via an OBUFT driven from O_sdo/O_sdo_oe) and the ADC control logic.

Parameters:
- ADDR_SIZE, 8, address bits used from the 13-bit instruction address field; range 1..13; must satisfy 2^ADDR_SIZE >= NUM_REGS.
- DATA_SIZE, 8, bits per data word.
- NUM_REGS, 16, number of implemented registers, at addresses 0..NUM_REGS-1.
- RESET_VAL, 0, flattened NUM_REGS*DATA_SIZE reset values; register i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- RO_MASK, 0, NUM_REGS bits; bit i = 1 makes register i read-only, sourced from I_ro_data.

Ports:
- I_clk  in  1  system clock; must run at >= 8x the SCLK frequency.
- _I_rstb  in  1  asynchronous active-low reset.
- I_sclk  in  1  SPI clock, asynchronous; CPOL=0, CPHA=0.
- _I_csb  in  1  SPI chip select, active low, asynchronous.
- I_sdi  in  1  SPI serial data in.
- O_sdo  out  1  SPI serial data out.
- O_sdo_oe  out  1  SDO output enable (top-level T = !O_sdo_oe).
- I_ro_data  in  NUM_REGS*DATA_SIZE  read-only register sources.
- O_regs  out  NUM_REGS*DATA_SIZE  flattened register contents.
- O_wr_stb  out  1  one-cycle pulse per committed write.
- O_wr_addr  out  ADDR_SIZE  address of the last committed write.
- O_busy  out  1  synchronised CSB active.

Behaviour:
- Reset: all registers load RESET_VAL; O_sdo=0, O_sdo_oe=0, O_wr_stb=0, O_wr_addr=0, O_busy=0; FSM goes to IDLE. Reset mid-transaction aborts the transaction; no partial write.
- Inputs pass through 2-FF synchronisers plus an edge-detect register. A SCLK rising or falling event is seen 3 I_clk cycles after the pin edge.
- Instruction word is 16 bits, MSB first:
  - bit15: R/W (1 = read).
  - bits14:13: W (00=1 word, 01=2, 10=3, 11=streaming until CSB high).
  - bits12:0: address; only the low ADDR_SIZE bits are used.
- SDI is sampled on detected SCLK rising edges. SDO changes on detected SCLK falling edges.
- FSM states and transitions:
  - IDLE: CSB falling -> INSTR; bit counter cleared.
  - INSTR: after 16 rising edges, latch R/W, W and address -> DATA.
  - DATA: after DATA_SIZE bits a word completes. Word counter increments; address decrements modulo 2^ADDR_SIZE. When the word count is reached (non-streaming) -> DONE.
  - DONE: further SCLK edges are ignored; SDO is held.
  - Any state: synchronised CSB high -> IDLE. A partial word is discarded and O_sdo_oe drops the next cycle.
- Write commit:
  - Occurs on the cycle after the final bit's rising-edge detection.
  - The target register updates on that cycle; O_wr_stb pulses and O_wr_addr is loaded.
  - A write is ignored (no strobe, no update) when the address is >= NUM_REGS or RO_MASK[addr] = 1.
- Read:
  - At each word boundary (end of instruction or of the previous data word), the shift register loads the value at the current address.
  - The value is the register, or I_ro_data for read-only registers, or 0 when out of range.
  - MSB is driven on the next detected falling edge; subsequent bits shift out on subsequent falling edges.
  - O_sdo_oe = 1 from the first data-phase falling edge until CSB high.
- Write and read operate on the same bank. I_ro_data is sampled at word-load time, not continuously.
- O_busy tracks synchronised CSB low.

Decomposition:
- Package spi_regbank_pkg holds:
  - INSTR_SIZE=16.
  - Field positions RW_BIT=15, W_MSB=14, W_LSB=13, ADDR_FIELD=13.
  - W encoding constants W_1, W_2, W_3, W_STREAM.
  - FSM state enum {IDLE, INSTR, DATA, DONE}.
- One sub-module, spi_sync_edge: a 2-FF synchroniser plus rise/fall detect. It is instantiated for SCLK, CSB and SDI (SDI uses the synchronised level only).

Test Plan:
- Single write, instr 0x0006 then data 0xA5 -> O_regs[6]=0xA5; one O_wr_stb with O_wr_addr=6; O_sdo_oe stays 0.
- Read back, instr 0x8006 -> SDO carries 1,0,1,0,0,1,0,1 on consecutive rising edges; O_sdo_oe=1 during the data phase only.
- Streaming write, instr 0x6003 then data 0x11,0x22,0x33,0x44,0x55 -> reg3=0x11, reg2=0x22, reg1=0x33, reg0=0x44; address wraps to 0xFF (out of range) so 0x55 is dropped; exactly 4 strobes.
- W=01 with 3 data words, instr 0x2005 then 0x01,0x02,0x03 -> reg5=0x01, reg4=0x02; the third word is ignored; reg3 is unchanged.
- Abort, CSB high after 4 data bits of a write to addr 2 -> reg2 is unchanged and no strobe fires. A following full transaction succeeds. _I_rstb low mid-instruction -> all registers return to RESET_VAL.
- Read-only, with RO_MASK bit 9 set and I_ro_data[9]=0x3C: a write of 0xFF to addr 9 produces no strobe; a read of addr 9 returns 0x3C; a read of addr 20 returns 0x00.
